flux_rr_scheduler: RTL and testbench
====================================

Name: flux_rr_scheduler

Overview:
Arbiter and sequencer that shares one single-stream dataflow actor (clipper-class) between FLUX independent input FIFOs. Each cycle it picks one non-empty input FIFO, pops it, and registers the word with its flux tag into a one-entry output stage. The stage drives the actor's tagged input FIFO. Grants are round-robin with bounded bursts, so no flux starves behind a busy higher-index flux.

Parameters:
FLUX, 2, number of input FIFOs / data fluxes (>=1)
DATA_WIDTH, 16, payload width per flux
BURST_LEN, 4, max consecutive pops granted to one flux before rotation (>=1)
TAG_WIDTH, max(1,$clog2(FLUX)), derived; tag prepended to payload

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; low = no new pops, output stage still drains
in_empty  in  FLUX  per-flux input FIFO empty flags
in_dout  in  FLUX*DATA_WIDTH  per-flux FIFO head data, flux i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_read  out  FLUX  per-flux pop strobe, one-hot or zero
out_full  in  1  downstream (actor input) FIFO full
out_write  out  1  downstream push strobe
out_din  out  TAG_WIDTH+DATA_WIDTH  {tag, payload}
busy  out  1  high when state==GRANT or output stage valid

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=FLUX-1 (first search starts at flux 0), burst_cnt=0, out_valid=0, out_din=0. in_read=0, out_write=0, busy=0 throughout reset.
- Output stage: out_write = out_valid & ~out_full, combinational. slot_free = ~out_valid | out_write. A pop loads {tag, in_dout[tag]} into out_din and sets out_valid at the next edge. If out_write fires with no pop, out_valid clears. out_din holds its value while out_full is high.
- Latency: pop in cycle N -> out_write earliest in cycle N+1.
- Eligible flux i: in_empty[i]==0.
- IDLE: if en & slot_free & any eligible, then g = first eligible searching rr_ptr+1, rr_ptr+2, ... modulo FLUX. Assert in_read[g]=1, load the output stage, set rr_ptr<=g, burst_cnt<=1, go to GRANT. Otherwise stay in IDLE with no pop.
- GRANT (current flux = rr_ptr):
  - If en & slot_free & ~in_empty[rr_ptr] & burst_cnt<BURST_LEN: pop rr_ptr, burst_cnt++.
  - Else if ~en, or in_empty[rr_ptr], or burst_cnt==BURST_LEN: go to IDLE, no pop this cycle (one-cycle bubble, fixed by design).
  - Else (slot not free only): hold GRANT; burst_cnt unchanged.
- in_read is never asserted while the target FIFO is empty or slot_free==0. At most one in_read bit is set per cycle.
- Backpressure: while out_full is high with the slot occupied, no pops occur. At most one word is ever held internally, so no loss and per-flux order is preserved.
- FLUX=1: tag is always 0; round-robin degenerates to bursts with bubbles.
- Mid-operation reset clears the held word; upstream FIFOs have already been popped for that word (data lost, acceptable by design).

Optional Feature:
STRICT_PRIO_EN defined: IDLE selects the highest-index eligible flux regardless of rr_ptr, matching fixed-priority actor selection. BURST_LEN still bounds a burst, but after rotation the same high flux wins again if non-empty. Undefined: round-robin as above.

Test Plan:
1. Reset: rst_n=0 for 5 cycles, both FIFOs non-empty -> in_read=0, out_write=0, out_din=0. First cycle after release: in_read=2'b01. Next cycle: out_write=1, out_din tag 0.
2. Round-robin: FLUX=2, BURST_LEN=4, 8 words per FIFO, out_full=0 -> in_read sequence 01,01,01,01,00,10,10,10,10,00,01... Each out_din tag matches the pop one cycle earlier, payloads in FIFO order.
3. Backpressure: out_full=1 for 3 cycles mid-burst -> out_write=0, out_din stable, zero pops in those cycles. After release, data resumes with no gap or duplicate.
4. Early empty: flux 0 has 2 words, flux 1 has 5 -> pops 0,0, bubble, 1,1,1,1, bubble, 1. in_read never high while the target flux's in_empty is high.
5. Enable: en dropped after the 2nd pop of a burst -> no further in_read, the held word is written, busy falls one cycle after the stage empties. en high -> grant resumes at rr_ptr+1.
6. STRICT_PRIO_EN: both FIFOs non-empty -> only flux 1 popped (bursts of 4 separated by bubbles) until it empties, then flux 0.

Source files
------------

// File: rtl/flux_rr_scheduler.sv
// Purpose: shares one tagged single-stream actor among FLUX input FIFOs with round-robin, burst-bounded grants (STRICT_PRIO_EN selects highest-index-first).
// Latency: pop in cycle N -> out_write earliest in cycle N+1; one-cycle bubble whenever a burst ends.
// Backpressure: one-word output stage; no pops while the stage is held by out_full, so nothing is dropped and per-flux order is preserved.
module flux_rr_scheduler #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [FLUX-1:0]                 in_empty,
    input  logic [FLUX*DATA_WIDTH-1:0]      in_dout,
    output logic [FLUX-1:0]                 in_read,
    input  logic                            out_full,
    output logic                            out_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din,
    output logic                            busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                          state_q, state_d;
    logic [TAG_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                burst_cnt_q, burst_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din_q, out_din_d;

    logic                 slot_free;
    logic                 grant_ok;
    logic                 any_elig;
    logic [TAG_WIDTH-1:0] pick;
    logic                 cur_empty;
    logic                 pop;
    logic [TAG_WIDTH-1:0] pop_sel;
    logic [DATA_WIDTH-1:0] pop_dat;

    assign out_write = out_valid_q & ~out_full;
    assign slot_free = ~out_valid_q | out_write;
    // rst_n gates grants so nothing is popped while reset is held
    assign grant_ok  = en & rst_n & slot_free;
    assign busy      = (state_q == GRANT) | out_valid_q;
    assign out_din   = out_din_q;

`ifdef STRICT_PRIO_EN
    always_comb begin
        pick     = '0;
        any_elig = 1'b0;
        for (int i = 0; i < FLUX; i++) begin
            if (!in_empty[i]) begin
                pick     = TAG_WIDTH'(i);
                any_elig = 1'b1;
            end
        end
    end
`else
    logic                 found_hi, found_lo;
    logic [TAG_WIDTH-1:0] pick_hi, pick_lo;

    // Lowest eligible index above rr_ptr wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (!in_empty[i]) begin
                if (i > int'(rr_ptr_q)) begin
                    pick_hi  = TAG_WIDTH'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo  = TAG_WIDTH'(i);
                    found_lo = 1'b1;
                end
            end
        end
        pick     = found_hi ? pick_hi : pick_lo;
        any_elig = found_hi | found_lo;
    end
`endif

    always_comb begin
        cur_empty = 1'b1;
        for (int i = 0; i < FLUX; i++) begin
            if (rr_ptr_q == TAG_WIDTH'(i)) cur_empty = in_empty[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        pop         = 1'b0;
        pop_sel     = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant_ok && any_elig) begin
                    pop         = 1'b1;
                    pop_sel     = pick;
                    rr_ptr_d    = pick;
                    burst_cnt_d = CNT_W'(1);
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (grant_ok && !cur_empty && (burst_cnt_q < CNT_W'(BURST_LEN))) begin
                    pop         = 1'b1;
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else if (!en || cur_empty || (burst_cnt_q == CNT_W'(BURST_LEN))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_dat = '0;
        in_read = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (pop_sel == TAG_WIDTH'(i)) begin
                pop_dat    = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
                in_read[i] = pop;
            end
        end
    end

    always_comb begin
        out_valid_d = pop | (out_valid_q & ~out_write);
        out_din_d   = pop ? {pop_sel, pop_dat} : out_din_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= TAG_WIDTH'(FLUX - 1);
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_din_q   <= out_din_d;
        end
    end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed, table-driven bench for flux_rr_scheduler (FLUX=2, DATA_WIDTH=16, BURST_LEN=4).
module tb_flux_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  in_empty;
    logic [31:0] in_dout;
    logic [1:0]  in_read;
    logic        out_full;
    logic        out_write;
    logic [16:0] out_din;
    logic        busy;

    flux_rr_scheduler #(.FLUX(2), .DATA_WIDTH(16), .BURST_LEN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_empty (in_empty),
        .in_dout  (in_dout),
        .in_read  (in_read),
        .out_full (out_full),
        .out_write(out_write),
        .out_din  (out_din),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          seg;
        logic        en;
        logic        full;
        logic [1:0]  rd;
        logic        wr;
        logic        chk_din;
        logic [16:0] din;
        logic        busy;
    } vec_t;

    vec_t        vt[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic void add(input int seg, input logic e, input logic f, input logic [1:0] rd,
                                input logic wr, input logic chk, input logic [16:0] din, input logic b);
        vec_t v;
        v.seg = seg; v.en = e; v.full = f; v.rd = rd; v.wr = wr;
        v.chk_din = chk; v.din = din; v.busy = b;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic update_inputs();
        in_empty[0]    = (q0.size() == 0);
        in_empty[1]    = (q1.size() == 0);
        in_dout[15:0]  = (q0.size() != 0) ? q0[0] : 16'h0;
        in_dout[31:16] = (q1.size() != 0) ? q1[0] : 16'h0;
    endtask

    task automatic load(input int which, input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            if (which == 0) q0.push_back(base + 16'(k));
            else            q1.push_back(base + 16'(k));
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst_n = 1'b0;
            en = 1'b1;
            out_full = 1'b0;
            update_inputs();
            #1;
            check("rst_in_read", 32'(in_read), 32'h0);
            check("rst_out_write", 32'(out_write), 32'h0);
            check("rst_out_din", 32'(out_din), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            @(posedge clk);
        end
    endtask

    task automatic run_seg(input int seg);
        logic [1:0] rd;
        int         idx;
        idx = 0;
        foreach (vt[i]) begin
            if (vt[i].seg == seg) begin
                @(negedge clk);
                rst_n = 1'b1;
                en = vt[i].en;
                out_full = vt[i].full;
                update_inputs();
                #1;
                check($sformatf("s%0d.%0d_in_read", seg, idx), 32'(in_read), 32'(vt[i].rd));
                check($sformatf("s%0d.%0d_out_write", seg, idx), 32'(out_write), 32'(vt[i].wr));
                if (vt[i].chk_din)
                    check($sformatf("s%0d.%0d_out_din", seg, idx), 32'(out_din), 32'(vt[i].din));
                check($sformatf("s%0d.%0d_busy", seg, idx), 32'(busy), 32'(vt[i].busy));
                check($sformatf("s%0d.%0d_read_legal", seg, idx),
                      32'(((in_read & in_empty) == 2'b00) && (in_read != 2'b11)), 32'h1);
                rd = in_read;
                @(posedge clk);
                if (rd[0] && q0.size() != 0) void'(q0.pop_front());
                if (rd[1] && q1.size() != 0) void'(q1.pop_front());
                idx++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        out_full = 1'b0;
        in_empty = 2'b11;
        in_dout  = '0;

`ifdef STRICT_PRIO_EN
        // flux 1 wins every arbitration until it drains
        add(1,1,0,2'b10,0,0,17'h0,0);
        add(1,1,0,2'b10,1,1,17'h1B000,1);
        add(1,1,0,2'b10,1,1,17'h1B001,1);
        add(1,1,0,2'b10,1,1,17'h1B002,1);
        add(1,1,0,2'b00,1,1,17'h1B003,1);
        add(1,1,0,2'b10,0,0,17'h0,0);
        add(1,1,0,2'b00,1,1,17'h1B004,1);
        add(1,1,0,2'b00,1,1,17'h1B005,1);
        add(1,1,0,2'b01,0,0,17'h0,0);
        add(1,1,0,2'b01,1,1,17'h0A000,1);
        add(1,1,0,2'b00,1,1,17'h0A001,1);
        add(1,1,0,2'b00,0,0,17'h0,0);
        vt[6].rd = 2'b10;
        load(0, 16'hA000, 2);
        load(1, 16'hB000, 6);
        do_reset(5);
        run_seg(1);
`else
        // seg 1: reset release then two full rounds of 4-word bursts
        add(1,1,0,2'b01,0,0,17'h0,0);
        add(1,1,0,2'b01,1,1,17'h0A000,1);
        add(1,1,0,2'b01,1,1,17'h0A001,1);
        add(1,1,0,2'b01,1,1,17'h0A002,1);
        add(1,1,0,2'b00,1,1,17'h0A003,1);
        add(1,1,0,2'b10,0,0,17'h0,0);
        add(1,1,0,2'b10,1,1,17'h1B000,1);
        add(1,1,0,2'b10,1,1,17'h1B001,1);
        add(1,1,0,2'b10,1,1,17'h1B002,1);
        add(1,1,0,2'b00,1,1,17'h1B003,1);
        add(1,1,0,2'b01,0,0,17'h0,0);
        add(1,1,0,2'b01,1,1,17'h0A004,1);
        add(1,1,0,2'b01,1,1,17'h0A005,1);
        add(1,1,0,2'b01,1,1,17'h0A006,1);
        add(1,1,0,2'b00,1,1,17'h0A007,1);
        add(1,1,0,2'b10,0,0,17'h0,0);
        add(1,1,0,2'b10,1,1,17'h1B004,1);
        add(1,1,0,2'b10,1,1,17'h1B005,1);
        add(1,1,0,2'b10,1,1,17'h1B006,1);
        add(1,1,0,2'b00,1,1,17'h1B007,1);
        add(1,1,0,2'b00,0,0,17'h0,0);
        // seg 2: out_full held 3 cycles mid-burst
        add(2,1,0,2'b01,0,0,17'h0,0);
        add(2,1,0,2'b01,1,1,17'h0A100,1);
        add(2,1,1,2'b00,0,1,17'h0A101,1);
        add(2,1,1,2'b00,0,1,17'h0A101,1);
        add(2,1,1,2'b00,0,1,17'h0A101,1);
        add(2,1,0,2'b01,1,1,17'h0A101,1);
        add(2,1,0,2'b01,1,1,17'h0A102,1);
        add(2,1,0,2'b00,1,1,17'h0A103,1);
        add(2,1,0,2'b01,0,0,17'h0,0);
        add(2,1,0,2'b01,1,1,17'h0A104,1);
        add(2,1,0,2'b00,1,1,17'h0A105,1);
        add(2,1,0,2'b00,0,0,17'h0,0);
        // seg 3: flux 0 runs dry after two words
        add(3,1,0,2'b01,0,0,17'h0,0);
        add(3,1,0,2'b01,1,1,17'h0C000,1);
        add(3,1,0,2'b00,1,1,17'h0C001,1);
        add(3,1,0,2'b10,0,0,17'h0,0);
        add(3,1,0,2'b10,1,1,17'h1D000,1);
        add(3,1,0,2'b10,1,1,17'h1D001,1);
        add(3,1,0,2'b10,1,1,17'h1D002,1);
        add(3,1,0,2'b00,1,1,17'h1D003,1);
        add(3,1,0,2'b10,0,0,17'h0,0);
        add(3,1,0,2'b00,1,1,17'h1D004,1);
        add(3,1,0,2'b00,0,0,17'h0,0);
        // seg 4: en dropped after the second pop, then restored
        add(4,1,0,2'b01,0,0,17'h0,0);
        add(4,1,0,2'b01,1,1,17'h0E000,1);
        add(4,0,0,2'b00,1,1,17'h0E001,1);
        add(4,0,0,2'b00,0,0,17'h0,0);
        add(4,0,0,2'b00,0,0,17'h0,0);
        add(4,1,0,2'b10,0,0,17'h0,0);
        add(4,1,0,2'b10,1,1,17'h1F000,1);
        add(4,1,0,2'b00,1,1,17'h1F001,1);
        add(4,1,0,2'b01,0,0,17'h0,0);
        add(4,1,0,2'b01,1,1,17'h0E002,1);
        add(4,1,0,2'b00,1,1,17'h0E003,1);
        add(4,1,0,2'b00,0,0,17'h0,0);
        // seg 5/6: reset while a word is held discards it
        add(5,1,0,2'b01,0,0,17'h0,0);
        add(6,1,0,2'b01,0,0,17'h0,0);
        add(6,1,0,2'b00,1,1,17'h0A201,1);
        add(6,1,0,2'b00,0,0,17'h0,0);

        load(0, 16'hA000, 8);
        load(1, 16'hB000, 8);
        do_reset(5);
        run_seg(1);

        load(0, 16'hA100, 6);
        run_seg(2);

        do_reset(1);
        load(0, 16'hC000, 2);
        load(1, 16'hD000, 5);
        run_seg(3);

        load(0, 16'hE000, 4);
        load(1, 16'hF000, 2);
        run_seg(4);

        load(0, 16'hA200, 2);
        run_seg(5);
        do_reset(2);
        run_seg(6);
`endif

        check("fifo0_drained", 32'(q0.size()), 32'h0);
        check("fifo1_drained", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
